// File: rtl/seg_display_decoder_if.sv
// seg_display_decoder_if
//   Bundles the multiplexed 7-segment bus with the decoder's frame reports.
//   Signals:
//     annodes    [3:0]  digit enables, active-low (bit i = digit i)
//     seg        [6:0]  segments, active-low, seg[0]=a .. seg[6]=g
//     data       [15:0] last complete decoded frame
//     data_valid        1-cycle pulse when data is updated
//     frame_err         1-cycle pulse on illegal glyph or multi-anode entry
//     digit_mask [3:0]  digits captured so far in the current frame
//   Modports:
//     master  drives the display bus, observes the reports (board/bench side)
//     slave   the decoder itself
//   Handshake: there is no back-pressure. data is qualified by data_valid,
//   which is high for exactly one clk per reported frame; a consumer must
//   take data in that cycle or read the held value later.
interface seg_display_decoder_if;
  logic [3:0]  annodes;
  logic [6:0]  seg;
  logic [15:0] data;
  logic        data_valid;
  logic        frame_err;
  logic [3:0]  digit_mask;

  modport master (
    output annodes, seg,
    input  data, data_valid, frame_err, digit_mask
  );

  modport slave (
    input  annodes, seg,
    output data, data_valid, frame_err, digit_mask
  );
endinterface

// File: rtl/seg_display_decoder.sv
// seg_display_decoder
//   Receive side of a 4-digit multiplexed 7-segment display. Synchronizes
//   annodes/seg, waits for each anode pattern to settle, decodes the lit
//   glyph back to a hex nibble and reassembles the 16-bit value. Each
//   complete frame is reported with a one-cycle data_valid pulse.
// Parameters:
//   SETTLE_CYCLES  clk cycles a synchronized anode pattern must hold before
//                  seg is sampled (>= 2)
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   bus        seg_display_decoder_if.slave (annodes, seg in; data,
//              data_valid, frame_err, digit_mask out)
//   state_dbg  current FSM state (0 IDLE, 1 SETTLE, 2 SAMPLED)
// Configuration:
//   SEGDEC_CHANGE_ONLY_EN  when defined, a complete frame equal to the
//                          current data does not pulse data_valid.
module seg_display_decoder #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_display_decoder_if.slave  bus,
  output logic [1:0]            state_dbg
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    SAMPLED = 2'd2
  } state_t;

  state_t state_q, state_nx;

  logic [3:0]    ann_s1, ann_s2, ann_prev;
  logic [6:0]    seg_s1, seg_s2;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [15:0]   shadow_q, shadow_nx;
  logic [15:0]   data_q, data_nx;
  logic [3:0]    mask_q, mask_nx;
  logic          valid_q, valid_nx;
  logic          err_q, err_nx;

  logic          cls_one, cls_none, cls_multi, prev_multi, changed;
  logic [1:0]    idx;
  logic [4:0]    dec;
  logic [3:0]    mask_base, mask_new;
  logic [15:0]   frame_w;

  // Active-high glyphs as produced by hex_display; bit 4 of the result is
  // the match flag.
  function automatic logic [4:0] decode_glyph(input logic [6:0] lit);
    case (lit)
      7'h3F:   return {1'b1, 4'h0};
      7'h06:   return {1'b1, 4'h1};
      7'h5B:   return {1'b1, 4'h2};
      7'h4F:   return {1'b1, 4'h3};
      7'h66:   return {1'b1, 4'h4};
      7'h6D:   return {1'b1, 4'h5};
      7'h7D:   return {1'b1, 4'h6};
      7'h07:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h6F:   return {1'b1, 4'h9};
      7'h77:   return {1'b1, 4'hA};
      7'h7C:   return {1'b1, 4'hB};
      7'h39:   return {1'b1, 4'hC};
      7'h5E:   return {1'b1, 4'hD};
      7'h79:   return {1'b1, 4'hE};
      7'h71:   return {1'b1, 4'hF};
      default: return 5'b0_0000;
    endcase
  endfunction

  // Two-flop synchronizers. Idle values are "all off" so reset looks like
  // a blanked display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ann_s1   <= 4'hF;
      ann_s2   <= 4'hF;
      ann_prev <= 4'hF;
      seg_s1   <= 7'h7F;
      seg_s2   <= 7'h7F;
    end else begin
      ann_s1   <= bus.annodes;
      ann_s2   <= ann_s1;
      ann_prev <= ann_s2;
      seg_s1   <= bus.seg;
      seg_s2   <= seg_s1;
    end
  end

  always_comb begin
    cls_none   = (ann_s2 == 4'hF);
    cls_one    = ($countones(~ann_s2) == 1);
    cls_multi  = !cls_none && !cls_one;
    prev_multi = ($countones(~ann_prev) > 1);
    changed    = (ann_s2 != ann_prev);
    case (ann_s2)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    dec = decode_glyph(~seg_s2);
  end

  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    shadow_nx = shadow_q;
    data_nx   = data_q;
    valid_nx  = 1'b0;
    err_nx    = 1'b0;
    frame_w   = shadow_q;
    // A full mask is only shown for the cycle data_valid is high.
    mask_base = (mask_q == 4'hF) ? 4'h0 : mask_q;
    mask_new  = mask_base | (4'b0001 << idx);
    mask_nx   = mask_base;

    if (cls_multi) begin
      // Ghosting / multiple digits lit: drop the frame, report once on entry.
      state_nx = IDLE;
      cnt_nx   = '0;
      mask_nx  = 4'h0;
      err_nx   = !prev_multi;
    end else begin
      case (state_q)
        IDLE: begin
          if (cls_one) begin
            state_nx = SETTLE;
            cnt_nx   = '0;
          end
        end
        SETTLE, SAMPLED: begin
          if (changed) begin
            state_nx = cls_one ? SETTLE : IDLE;
            cnt_nx   = '0;
          end else if (state_q == SETTLE) begin
            if (cnt_q == CNT_LAST) begin
              state_nx = SAMPLED;
              if (dec[4]) begin
                shadow_nx[4*idx +: 4] = dec[3:0];
                frame_w               = shadow_nx;
                mask_nx               = mask_new;
                if (mask_new == 4'hF) begin
                  data_nx = frame_w;
`ifdef SEGDEC_CHANGE_ONLY_EN
                  valid_nx = (frame_w != data_q);
`else
                  valid_nx = 1'b1;
`endif
                end
              end else begin
                err_nx  = 1'b1;
                mask_nx = 4'h0;
              end
            end else begin
              cnt_nx = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= 16'h0;
      data_q   <= 16'h0;
      mask_q   <= 4'h0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_nx;
      cnt_q    <= cnt_nx;
      shadow_q <= shadow_nx;
      data_q   <= data_nx;
      mask_q   <= mask_nx;
      valid_q  <= valid_nx;
      err_q    <= err_nx;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.digit_mask = mask_q;
  assign state_dbg      = state_q;

endmodule
